// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the execute-stage flag logic.
//   - ALU func codes that the condition-code register cares about
//   - bit positions of Z/N/C inside the 3-bit CCR and the ALU outFlags word
//   - conditional branch encodings and helpers that map them to flags
package cpu_pkg;

   localparam logic [3:0] FUNC_ADD = 4'b1000;
   localparam logic [3:0] FUNC_SUB = 4'b1001;
   localparam logic [3:0] FUNC_AND = 4'b1010;
   localparam logic [3:0] FUNC_OR  = 4'b1011;
   localparam logic [3:0] FUNC_SHL = 4'b1100;
   localparam logic [3:0] FUNC_SHR = 4'b1101;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;

   typedef enum logic [1:0] {
      BR_JZ  = 2'b00,
      BR_JN  = 2'b01,
      BR_JC  = 2'b10,
      BR_JMP = 2'b11
   } br_cond_e;

   // Which flags a func code is allowed to write.
   typedef struct packed {
      logic zn;
      logic c;
   } upd_mask_t;

   function automatic upd_mask_t func_mask(input logic [3:0] func);
      upd_mask_t m;
      m = '0;
      case (func)
         FUNC_ADD, FUNC_SUB, FUNC_SHL, FUNC_SHR: begin
            m.zn = 1'b1;
            m.c  = 1'b1;
         end
         FUNC_AND, FUNC_OR: m.zn = 1'b1;
         default: m = '0;
      endcase
      return m;
   endfunction

   // Flag tested by a conditional branch. JMP tests nothing; the caller
   // must qualify with the JMP decode before using the index.
   function automatic logic [1:0] flag_idx(input br_cond_e cond);
      logic [1:0] idx;
      case (cond)
         BR_JZ:   idx = 2'(FLAG_Z);
         BR_JN:   idx = 2'(FLAG_N);
         BR_JC:   idx = 2'(FLAG_C);
         default: idx = 2'(FLAG_Z);
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/flag_shadow_stack.sv
// LIFO of 3-bit CCR snapshots used across interrupt entry/return.
// Ports:
//   clk, rst_n      clock, async active-low reset (clears all entries)
//   push, pop       one operation per cycle; push ignored when full,
//                   pop ignored when empty, pop wins if both are set
//   push_data       snapshot to store
//   top_data        most recently pushed entry (0 when empty)
//   count           occupied entries
//   full, empty     occupancy flags
module flag_shadow_stack #(
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [2:0]       push_data,
   output logic [2:0]       top_data,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [2:0]       entry_q [DEPTH];
   logic [2:0]       entry_d [DEPTH];
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

   always_comb begin
      entry_d  = entry_q;
      count_d  = count_q;
      top_data = '0;
      // Compare-based selection keeps the index width independent of DEPTH.
      for (int i = 0; i < DEPTH; i++) begin
         if (count_q == CNT_W'(i + 1)) top_data = entry_q[i];
      end
      if (pop && !empty) begin
         count_d = count_q - CNT_W'(1);
      end else if (push && !full) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (count_q == CNT_W'(i)) entry_d[i] = push_data;
         end
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      end else begin
         count_q <= count_d;
         entry_q <= entry_d;
      end
   end

endmodule

// File: rtl/flag_register_unit.sv
// Condition-code register sitting after the ALU in EX.
// Latches Z/N/C from the ALU under a func-code mask, applies SETC/CLRC,
// resolves conditional branches against the same-cycle (bypassed) flags,
// clears the tested flag on a taken conditional branch, and saves/restores
// the flags through a shadow stack on interrupt entry / RTI.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   stall                 freezes all state and suppresses br_taken
//   ex_valid, ex_func     EX instruction valid and its ALU func code
//   alu_flags             ALU outFlags (bit0 Z, bit1 N, bit2 C)
//   setc, clrc            carry set/clear (clrc wins)
//   br_valid, br_cond     branch evaluation request and condition
//   br_taken              combinational branch decision
//   int_save, rti_restore push / pop the CCR
//   ccr                   registered {C,N,Z}
//   shadow_count          occupied shadow entries
//   shadow_err            sticky misuse flag (overflow, underflow, both)
module flag_register_unit
   import cpu_pkg::*;
#(
   parameter  int SHADOW_DEPTH     = 2,
   parameter  bit CONSUME_ON_TAKEN = 1'b1,
   localparam int CNT_W            = $clog2(SHADOW_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             ex_valid,
   input  logic [3:0]       ex_func,
   input  logic [15:0]      alu_flags,
   input  logic             setc,
   input  logic             clrc,
   input  logic             br_valid,
   input  logic [1:0]       br_cond,
   output logic             br_taken,
   input  logic             int_save,
   input  logic             rti_restore,
   output logic [2:0]       ccr,
   output logic [CNT_W-1:0] shadow_count,
   output logic             shadow_err
);

   upd_mask_t  mask;
   br_cond_e   cond;
   logic [1:0] tidx;
   logic       is_jmp;
   logic       taken;
   logic [2:0] upd;
   logic [2:0] nxt;
   logic [2:0] ccr_d, ccr_q;
   logic       err_d, err_q;
   logic [2:0] top_data;
   logic       push, pop, full, empty;

   // Upper outFlags bits carry nothing this unit uses.
   logic       unused_ok;
   assign unused_ok = ^alu_flags[15:3];

   assign cond = br_cond_e'(br_cond);

   // Flag update, bypass and consume. The branch sees upd, so a flag the
   // ALU writes this cycle already steers the branch.
   always_comb begin
      mask   = func_mask(ex_func);
      upd    = ccr_q;
      if (ex_valid && mask.zn) begin
         upd[FLAG_Z] = alu_flags[FLAG_Z];
         upd[FLAG_N] = alu_flags[FLAG_N];
      end
      if (ex_valid && mask.c) upd[FLAG_C] = alu_flags[FLAG_C];
      if (clrc)      upd[FLAG_C] = 1'b0;
      else if (setc) upd[FLAG_C] = 1'b1;

      is_jmp = (cond == BR_JMP);
      tidx   = flag_idx(cond);
      taken  = br_valid && !stall && (is_jmp || upd[tidx]);

      nxt    = upd;
      if (CONSUME_ON_TAKEN && taken && !is_jmp) nxt[tidx] = 1'b0;
   end

   assign br_taken = taken;

   // A simultaneous save/restore performs only the restore.
   assign push = !stall && int_save && !rti_restore && !full;
   assign pop  = !stall && rti_restore && !empty;

   always_comb begin
      ccr_d = ccr_q;
      err_d = err_q;
      if (!stall) begin
         // A successful restore discards every other update this cycle.
         ccr_d = pop ? top_data : nxt;
         if ((int_save && rti_restore) || (int_save && full) ||
             (rti_restore && empty))
            err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ccr_q <= '0;
         err_q <= 1'b0;
      end else begin
         ccr_q <= ccr_d;
         err_q <= err_d;
      end
   end

   flag_shadow_stack #(
      .DEPTH (SHADOW_DEPTH)
   ) u_shadow (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .push_data (nxt),
      .top_data  (top_data),
      .count     (shadow_count),
      .full      (full),
      .empty     (empty)
   );

   assign ccr        = ccr_q;
   assign shadow_err = err_q;

endmodule

// File: tb/tb_flag_register_unit.sv
// Directed bench for flag_register_unit with a flag/stack model and a
// per-cycle comparison, plus literal checks at the key points.
module tb_flag_register_unit;

   localparam int D = 2;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        ex_valid;
   logic [3:0]  ex_func;
   logic [15:0] alu_flags;
   logic        setc;
   logic        clrc;
   logic        br_valid;
   logic [1:0]  br_cond;
   logic        br_taken;
   logic        int_save;
   logic        rti_restore;
   logic [2:0]  ccr;
   logic [1:0]  shadow_count;
   logic        shadow_err;

   int n_checks = 0;
   int n_errors = 0;

   flag_register_unit #(
      .SHADOW_DEPTH     (D),
      .CONSUME_ON_TAKEN (1'b1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .ex_valid     (ex_valid),
      .ex_func      (ex_func),
      .alu_flags    (alu_flags),
      .setc         (setc),
      .clrc         (clrc),
      .br_valid     (br_valid),
      .br_cond      (br_cond),
      .br_taken     (br_taken),
      .int_save     (int_save),
      .rti_restore  (rti_restore),
      .ccr          (ccr),
      .shadow_count (shadow_count),
      .shadow_err   (shadow_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   // Flags held as three separate bits, stack as an array plus depth counter.
   logic       m_z, m_n, m_c;
   logic [2:0] m_stk [D];
   int         m_cnt;
   logic       m_err;

   logic       u_z, u_n, u_c;
   logic       m_br;
   logic [2:0] m_next;
   logic [2:0] m_ccr_n;
   int         m_cnt_n;
   logic       m_err_n;
   logic       m_push;

   always_comb begin
      u_z = m_z; u_n = m_n; u_c = m_c;
      if (ex_valid && ex_func >= 4'd8 && ex_func <= 4'd13) begin
         u_z = alu_flags[0];
         u_n = alu_flags[1];
         if (ex_func != 4'd10 && ex_func != 4'd11) u_c = alu_flags[2];
      end
      if (setc) u_c = 1'b1;
      if (clrc) u_c = 1'b0;

      m_br = 1'b0;
      if (br_valid && !stall) begin
         if (br_cond == 2'd0) m_br = u_z;
         else if (br_cond == 2'd1) m_br = u_n;
         else if (br_cond == 2'd2) m_br = u_c;
         else m_br = 1'b1;
      end

      m_next = {u_c, u_n, u_z};
      if (m_br && br_cond == 2'd0) m_next = {u_c, u_n, 1'b0};
      if (m_br && br_cond == 2'd1) m_next = {u_c, 1'b0, u_z};
      if (m_br && br_cond == 2'd2) m_next = {1'b0, u_n, u_z};

      m_ccr_n = {m_c, m_n, m_z};
      m_cnt_n = m_cnt;
      m_err_n = m_err;
      m_push  = 1'b0;
      if (!stall) begin
         m_ccr_n = m_next;
         if (rti_restore) begin
            if (int_save) m_err_n = 1'b1;
            if (m_cnt > 0) begin
               m_ccr_n = m_stk[m_cnt-1];
               m_cnt_n = m_cnt - 1;
            end else begin
               m_err_n = 1'b1;
            end
         end else if (int_save) begin
            if (m_cnt < D) begin
               m_push  = 1'b1;
               m_cnt_n = m_cnt + 1;
            end else begin
               m_err_n = 1'b1;
            end
         end
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {m_c, m_n, m_z} <= 3'b000;
         m_cnt <= 0;
         m_err <= 1'b0;
         for (int i = 0; i < D; i++) m_stk[i] <= 3'b000;
      end else begin
         {m_c, m_n, m_z} <= m_ccr_n;
         m_cnt <= m_cnt_n;
         m_err <= m_err_n;
         if (m_push) m_stk[m_cnt] <= m_next;
      end
   end

   // Per-cycle comparison, away from the rising edge.
   always @(negedge clk) begin
      if (rst_n) begin
         check("cyc_br_taken", int'(br_taken), int'(m_br));
         check("cyc_ccr", int'(ccr), int'({m_c, m_n, m_z}));
         check("cyc_count", int'(shadow_count), m_cnt);
         check("cyc_err", int'(shadow_err), int'(m_err));
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      stall = 0; ex_valid = 0; ex_func = 4'd0; alu_flags = 16'h0;
      setc = 0; clrc = 0; br_valid = 0; br_cond = 2'd0;
      int_save = 0; rti_restore = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic ex(input logic [3:0] f, input logic [15:0] fl);
      idle();
      ex_valid = 1; ex_func = f; alu_flags = fl;
   endtask

   initial begin
      clk = 0;
      rst_n = 0;
      idle();
      #1;
      check("rst_ccr", int'(ccr), 0);
      check("rst_count", int'(shadow_count), 0);
      check("rst_err", int'(shadow_err), 0);
      check("rst_br", int'(br_taken), 0);
      @(posedge clk);
      #2;
      rst_n = 1;

      // Masked updates
      ex(4'b1001, 16'h0001); step(); check("sub_z", int'(ccr), 3'b001);
      ex(4'b1010, 16'h0006); step(); check("and_zn", int'(ccr), 3'b010);
      idle(); setc = 1;      step(); check("setc", int'(ccr), 3'b110);
      ex(4'b1010, 16'h0001); step(); check("and_keep_c", int'(ccr), 3'b101);
      ex(4'b0000, 16'hFFFF); step(); check("nop_func", int'(ccr), 3'b101);
      ex(4'b1000, 16'h0004); clrc = 1; step(); check("clrc_ovr", int'(ccr), 3'b000);
      idle(); setc = 1;      step(); check("setc2", int'(ccr), 3'b100);
      idle(); setc = 1; clrc = 1; step(); check("setc_clrc", int'(ccr), 3'b000);

      // Bypass and consume
      ex(4'b1001, 16'h0001); br_valid = 1; br_cond = 2'b00;
      #1; check("bypass_jz", int'(br_taken), 1);
      step(); check("jz_consume", int'(ccr), 3'b000);
      idle(); setc = 1; step();
      ex(4'b1001, 16'h0001); br_valid = 1; br_cond = 2'b00; stall = 1;
      #1; check("stall_br", int'(br_taken), 0);
      step(); check("stall_hold", int'(ccr), 3'b100);
      idle(); br_valid = 1; br_cond = 2'b01;
      #1; check("jn_not", int'(br_taken), 0);
      step();
      idle(); br_valid = 1; br_cond = 2'b10;
      #1; check("jc_taken", int'(br_taken), 1);
      step(); check("jc_consume", int'(ccr), 3'b000);
      idle(); setc = 1; step();
      idle(); br_valid = 1; br_cond = 2'b11;
      #1; check("jmp", int'(br_taken), 1);
      step(); check("jmp_keep", int'(ccr), 3'b100);

      // Shadow save/restore
      ex(4'b1001, 16'h0005); step(); check("sub_101", int'(ccr), 3'b101);
      idle(); int_save = 1; step(); check("save_cnt", int'(shadow_count), 1);
      ex(4'b1000, 16'h0002); step(); check("add_010", int'(ccr), 3'b010);
      idle(); rti_restore = 1; step();
      check("rti_ccr", int'(ccr), 3'b101);
      check("rti_cnt", int'(shadow_count), 0);
      check("rti_err", int'(shadow_err), 0);

      // Overflow / underflow
      for (int i = 0; i < 3; i++) begin
         idle(); int_save = 1; step();
      end
      check("ovf_cnt", int'(shadow_count), 2);
      check("ovf_err", int'(shadow_err), 1);
      ex(4'b1000, 16'h0000); step(); check("add_000", int'(ccr), 3'b000);
      idle(); rti_restore = 1; step(); check("pop1", int'(ccr), 3'b101);
      idle(); rti_restore = 1; step(); check("pop2", int'(ccr), 3'b101);
      idle(); rti_restore = 1; step();
      check("pop3_ccr", int'(ccr), 3'b101);
      check("pop3_err", int'(shadow_err), 1);

      // Async reset mid-sequence
      idle(); int_save = 1; step();
      idle(); int_save = 1; step();
      ex(4'b1001, 16'h0007); step();
      check("pre_rst_ccr", int'(ccr), 3'b111);
      check("pre_rst_cnt", int'(shadow_count), 2);
      idle(); stall = 1; int_save = 1;
      #1; rst_n = 0;
      #1;
      check("async_ccr", int'(ccr), 0);
      check("async_cnt", int'(shadow_count), 0);
      check("async_err", int'(shadow_err), 0);
      idle();
      @(posedge clk); #2; rst_n = 1;

      // Save and restore in the same cycle
      ex(4'b1001, 16'h0002); step(); check("sub_010", int'(ccr), 3'b010);
      idle(); int_save = 1; step();
      ex(4'b1000, 16'h0001); int_save = 1; rti_restore = 1; step();
      check("both_ccr", int'(ccr), 3'b010);
      check("both_cnt", int'(shadow_count), 0);
      check("both_err", int'(shadow_err), 1);

      // Mixed traffic, checked against the model each cycle
      for (int i = 0; i < 120; i++) begin
         idle();
         stall       = ($urandom_range(0, 3) == 0);
         ex_valid    = $urandom_range(0, 1) != 0;
         ex_func     = 4'($urandom_range(0, 15));
         alu_flags   = 16'($urandom);
         setc        = ($urandom_range(0, 4) == 0);
         clrc        = ($urandom_range(0, 4) == 0);
         br_valid    = $urandom_range(0, 1) != 0;
         br_cond     = 2'($urandom_range(0, 3));
         int_save    = ($urandom_range(0, 3) == 0);
         rti_restore = ($urandom_range(0, 3) == 0);
         #1;
         check("mix_br", int'(br_taken), int'(m_br));
         step();
      end

      idle();
      step();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
